// File: rtl/ldst_unit_pkg.sv
// Shared definitions for the load/store unit: FSM encoding and default parameters.
package ldst_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2,
    ST_ERR    = 2'd3
  } state_e;

  localparam int DEF_DW      = 8;
  localparam int DEF_AW      = 8;
  localparam int DEF_MAXLEN  = 4;
  localparam int DEF_TIMEOUT = 15;

endpackage

// File: rtl/ldst_timer.sv
// Per-beat watchdog: counts ack-less cycles and flags the last one before timeout.
module ldst_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  // High in the cycle whose edge would bring the count up to TIMEOUT.
  assign expired = (count == TW'(TIMEOUT - 1));

endmodule

// File: rtl/ldst_unit.sv
// Burst load/store engine between the core request port and an acked external bus.
module ldst_unit
  import ldst_unit_pkg::*;
#(
  parameter int DW      = DEF_DW,
  parameter int AW      = DEF_AW,
  parameter int MAXLEN  = DEF_MAXLEN,
  parameter int TIMEOUT = DEF_TIMEOUT,
  localparam int LW     = (MAXLEN > 1) ? $clog2(MAXLEN) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          Req_i,
  input  logic          Wr_i,
  input  logic [AW-1:0] Addr_i,
  input  logic [LW-1:0] Len_i,
  input  logic [DW-1:0] WData_i,
  output logic          Busy_o,
  output logic [DW-1:0] RData_o,
  output logic          RValid_o,
  output logic          Done_o,
  output logic          Err_o,
  output logic          RDRequest_o,
  output logic          WRRequest_o,
  output logic [AW-1:0] ExternAddr_o,
  output logic [DW-1:0] ExternVal_o,
  input  logic [DW-1:0] ExternVal_i,
  input  logic          ExternAck_i
);

  state_e        state;
  logic          wr_q;
  logic [LW-1:0] len_q;
  logic [LW-1:0] beat_q;
  logic          tmr_clr;
  logic          tmr_en;
  logic          tmr_expired;

  function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] len);
    if (int'(len) >= MAXLEN) return LW'(MAXLEN - 1);
    return len;
  endfunction

  assign tmr_en  = (state == ST_ACCESS);
  assign tmr_clr = (state != ST_ACCESS) || ExternAck_i;

  ldst_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  // Write data flows straight through so each beat can present fresh data without a bubble.
  assign ExternVal_o = WRRequest_o ? WData_i : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      Busy_o       <= 1'b0;
      RValid_o     <= 1'b0;
      Done_o       <= 1'b0;
      Err_o        <= 1'b0;
      RDRequest_o  <= 1'b0;
      WRRequest_o  <= 1'b0;
      ExternAddr_o <= '0;
      RData_o      <= '0;
      wr_q         <= 1'b0;
      len_q        <= '0;
      beat_q       <= '0;
    end else begin
      RValid_o <= 1'b0;
      Done_o   <= 1'b0;
      Err_o    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Req_i) begin
            state        <= ST_ACCESS;
            Busy_o       <= 1'b1;
            wr_q         <= Wr_i;
            len_q        <= clamp_len(Len_i);
            beat_q       <= '0;
            ExternAddr_o <= Addr_i;
            RDRequest_o  <= ~Wr_i;
            WRRequest_o  <= Wr_i;
          end
        end
        ST_ACCESS: begin
          // An ack in the timeout cycle still completes the beat.
          if (ExternAck_i) begin
            if (!wr_q) begin
              RData_o  <= ExternVal_i;
              RValid_o <= 1'b1;
            end
            if (beat_q == len_q) begin
              state       <= ST_DONE;
              RDRequest_o <= 1'b0;
              WRRequest_o <= 1'b0;
              Done_o      <= 1'b1;
            end else begin
              beat_q       <= beat_q + 1'b1;
              ExternAddr_o <= ExternAddr_o + 1'b1;
            end
          end else if (tmr_expired) begin
            state       <= ST_ERR;
            RDRequest_o <= 1'b0;
            WRRequest_o <= 1'b0;
            Done_o      <= 1'b1;
            Err_o       <= 1'b1;
          end
        end
        ST_DONE, ST_ERR: begin
          state  <= ST_IDLE;
          Busy_o <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          Busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
